// File: rtl/fmgen_ctrl.sv
// ==== fmgen_ctrl: paces PCM samples into fmgen and retunes cw_freq via mute/ramp/settle ====
// ==== rev 1.0 ====
`default_nettype none

module fmgen_ctrl #(
  parameter int unsigned SAMPLE_DIV   = 1000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STEP_HZ      = 10000,
  parameter int unsigned SETTLE_TICKS = 16,
  parameter logic [31:0] RESET_FREQ   = 32'd107900000
) (
  input  logic        clk_pcm,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  input  logic        tune_valid,
  input  logic [31:0] tune_freq,
  output logic        tune_ready,
  output logic [31:0] cw_freq,
  output logic [15:0] pcm_out,
  output logic        sample_tick,
  output logic        busy,
  output logic        underrun
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned SET_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [SET_W-1:0]   SET_LAST  = SET_W'(SETTLE_TICKS - 1);
  localparam logic [31:0]        STEP_U    = 32'(STEP_HZ);
  localparam logic signed [32:0] STEP_S    = 33'(STEP_HZ);
  localparam logic signed [32:0] STEP_N    = -STEP_S;

  localparam logic [1:0] ST_ON_AIR = 2'd0;
  localparam logic [1:0] ST_MUTE   = 2'd1;
  localparam logic [1:0] ST_RAMP   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [31:0]      cw_q, cw_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [15:0]      pcm_q, pcm_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [15:0]      mem_q [FIFO_DEPTH];

  logic               w_tick;
  logic               w_on_air;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic signed [32:0] w_diff;

  assign w_tick   = (cnt_q == TICK_LAST);
  assign w_on_air = (state_q == ST_ON_AIR);
  assign w_empty  = (lvl_q == '0);
  assign w_push   = s_valid && s_ready;
  assign w_pop    = w_on_air && w_tick && !w_empty;
  // 33-bit signed distance so the ramp can never wrap past either end of the 32-bit range
  assign w_diff   = $signed({1'b0, tgt_q}) - $signed({1'b0, cw_q});

  assign s_ready     = w_on_air && (lvl_q != LVL_FULL);
  assign tune_ready  = w_on_air;
  assign busy        = !w_on_air;
  assign sample_tick = w_tick;
  assign underrun    = w_on_air && w_tick && w_empty;
  assign cw_freq     = cw_q;
  assign pcm_out     = pcm_q;

  always_comb begin
    cnt_d   = w_tick ? '0 : cnt_q + CNT_W'(1);
    state_d = state_q;
    wr_d    = w_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = w_pop ? rd_q + PTR_W'(1) : rd_q;
    lvl_d   = lvl_q + LVL_W'(w_push) - LVL_W'(w_pop);
    cw_d    = cw_q;
    tgt_d   = tgt_q;
    pcm_d   = w_pop ? mem_q[rd_q] : pcm_q;
    set_d   = set_q;

    case (state_q)
      ST_ON_AIR: begin
        if (tune_valid) begin
          // flush wins over any push or pop landing on the same edge
          tgt_d   = tune_freq;
          state_d = ST_MUTE;
          wr_d    = '0;
          rd_d    = '0;
          lvl_d   = '0;
        end
      end
      ST_MUTE: begin
        if (w_tick) begin
          pcm_d   = '0;
          state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (w_tick) begin
          pcm_d = '0;
          if (w_diff > STEP_S) begin
            cw_d = cw_q + STEP_U;
          end else if (w_diff < STEP_N) begin
            cw_d = cw_q - STEP_U;
          end else begin
            cw_d    = tgt_q;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (w_tick) begin
          pcm_d = '0;
          if (set_q == SET_LAST) begin
            set_d   = '0;
            state_d = ST_ON_AIR;
          end else begin
            set_d = set_q + SET_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_ON_AIR;
      end
    endcase
  end

  always_ff @(posedge clk_pcm or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= ST_ON_AIR;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      cw_q    <= RESET_FREQ;
      tgt_q   <= RESET_FREQ;
      pcm_q   <= '0;
      set_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      cw_q    <= cw_d;
      tgt_q   <= tgt_d;
      pcm_q   <= pcm_d;
      set_q   <= set_d;
    end
  end

  // storage needs no reset: occupancy is tracked by lvl_q
  always_ff @(posedge clk_pcm) begin
    if (w_push) begin
      mem_q[wr_q] <= s_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fmgen_ctrl.sv
// ==== tb_fmgen_ctrl: directed, table-driven checks of fmgen_ctrl ====
// ==== rev 1.0 ====
`default_nettype none

module tb_fmgen_ctrl;

  localparam int unsigned SAMPLE_DIV   = 8;
  localparam int unsigned STEP_HZ      = 10000;
  localparam int unsigned SETTLE_TICKS = 2;
  localparam logic [31:0] RST_F        = 32'd100000000;

  logic        clk_pcm;
  logic        rst_n;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        tune_valid;
  logic [31:0] tune_freq;
  logic        tune_ready;
  logic [31:0] cw_freq;
  logic [15:0] pcm_out;
  logic        sample_tick;
  logic        busy;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  fmgen_ctrl #(
    .SAMPLE_DIV   (SAMPLE_DIV),
    .FIFO_DEPTH   (4),
    .STEP_HZ      (STEP_HZ),
    .SETTLE_TICKS (SETTLE_TICKS),
    .RESET_FREQ   (RST_F)
  ) dut (
    .clk_pcm     (clk_pcm),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .tune_valid  (tune_valid),
    .tune_freq   (tune_freq),
    .tune_ready  (tune_ready),
    .cw_freq     (cw_freq),
    .pcm_out     (pcm_out),
    .sample_tick (sample_tick),
    .busy        (busy),
    .underrun    (underrun)
  );

  initial begin
    clk_pcm = 1'b0;
    forever #5 clk_pcm = ~clk_pcm;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        push_en;
    logic [15:0] push_data;
    logic        tune_en;
    logic [31:0] tune_f;
    logic        exp_under;
    logic [15:0] exp_pcm;
    logic [31:0] exp_cw;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_pcm);
    #1;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (!sample_tick && n < 3 * SAMPLE_DIV) begin
      cyc();
      n++;
    end
    chk({name, "_tick_seen"}, 32'(sample_tick), 32'd1);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    s_valid    = 1'b0;
    tune_valid = 1'b0;
    repeat (3) @(negedge clk_pcm);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic run_row(input int idx);
    vec_t  v;
    string nm;
    v  = tbl[idx];
    nm = $sformatf("row%0d", idx);
    if (v.push_en) begin
      s_valid = 1'b1;
      s_data  = v.push_data;
      chk({nm, "_s_ready"}, 32'(s_ready), 32'd1);
      cyc();
      s_valid = 1'b0;
    end
    if (v.tune_en) begin
      tune_valid = 1'b1;
      tune_freq  = v.tune_f;
      cyc();
      tune_valid = 1'b0;
      chk({nm, "_acc_busy"}, 32'(busy), 32'd1);
      chk({nm, "_acc_tune_ready"}, 32'(tune_ready), 32'd0);
      chk({nm, "_acc_s_ready"}, 32'(s_ready), 32'd0);
    end
    wait_tick(nm);
    chk({nm, "_underrun"}, 32'(underrun), 32'(v.exp_under));
    cyc();
    chk({nm, "_pcm"}, 32'(pcm_out), 32'(v.exp_pcm));
    chk({nm, "_cw"}, cw_freq, v.exp_cw);
    chk({nm, "_busy"}, 32'(busy), 32'(v.exp_busy));
    chk({nm, "_underrun_gone"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;

    // push_en, data, tune_en, tune_f, exp_under, exp_pcm, exp_cw, exp_busy
    tbl[0]  = '{1'b1, 16'd100,   1'b0, 32'd0,         1'b0, 16'd100,   RST_F,         1'b0};
    tbl[1]  = '{1'b1, 16'd200,   1'b0, 32'd0,         1'b0, 16'd200,   RST_F,         1'b0};
    tbl[2]  = '{1'b1, 16'hFED4,  1'b0, 32'd0,         1'b0, 16'hFED4,  RST_F,         1'b0};
    tbl[3]  = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b1, 16'hFED4,  RST_F,         1'b0};
    tbl[4]  = '{1'b0, 16'd0,     1'b1, 32'd100035000, 1'b0, 16'd0,     RST_F,         1'b1};
    tbl[5]  = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd100010000, 1'b1};
    tbl[6]  = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd100020000, 1'b1};
    tbl[7]  = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd100030000, 1'b1};
    tbl[8]  = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd100035000, 1'b1};
    tbl[9]  = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd100035000, 1'b1};
    tbl[10] = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd100035000, 1'b0};
    tbl[11] = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b1, 16'd0,     32'd100035000, 1'b0};
    tbl[12] = '{1'b0, 16'd0,     1'b1, 32'd99995000,  1'b0, 16'd0,     RST_F,         1'b1};
    tbl[13] = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd99995000,  1'b1};
    tbl[14] = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd99995000,  1'b1};
    tbl[15] = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd99995000,  1'b0};
    tbl[16] = '{1'b0, 16'd0,     1'b1, 32'd99995000,  1'b0, 16'd0,     32'd99995000,  1'b1};
    tbl[17] = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd99995000,  1'b1};
    tbl[18] = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd99995000,  1'b1};
    tbl[19] = '{1'b0, 16'd0,     1'b0, 32'd0,         1'b0, 16'd0,     32'd99995000,  1'b0};

    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    tune_valid = 1'b0;
    tune_freq  = '0;

    #12;
    chk("rst_cw", cw_freq, RST_F);
    chk("rst_pcm", 32'(pcm_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_tune_ready", 32'(tune_ready), 32'd1);
    chk("rst_tick", 32'(sample_tick), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);

    // drain/underrun, then upward retune continuing from that state
    do_reset();
    for (int i = 0; i <= 11; i++) run_row(i);

    // downward and same-frequency retune from reset frequency
    do_reset();
    for (int i = 12; i <= 19; i++) run_row(i);

    // FIFO full: four accepts fill it, fifth waits for the first pop
    do_reset();
    s_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      s_data = 16'(k);
      chk($sformatf("full_acc%0d", k), 32'(s_ready), 32'd1);
      cyc();
    end
    chk("full_ready_low", 32'(s_ready), 32'd0);
    s_data = 16'd5;
    n = 0;
    seen = 1'b0;
    while (!s_ready && n < 40) begin
      if (sample_tick) seen = 1'b1;
      cyc();
      n++;
    end
    chk("full_tick_before_5th", 32'(seen), 32'd1);
    chk("full_5th_ready", 32'(s_ready), 32'd1);
    chk("full_pop1", 32'(pcm_out), 32'd1);
    cyc();
    s_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      wait_tick("full");
      cyc();
      chk($sformatf("full_pop%0d", k), 32'(pcm_out), 32'(k));
    end

    // flush on retune
    do_reset();
    s_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      s_data = 16'(10 * k);
      cyc();
    end
    s_valid    = 1'b0;
    tune_valid = 1'b1;
    tune_freq  = RST_F;
    cyc();
    tune_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_tick("flush");
      cyc();
    end
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_s_ready", 32'(s_ready), 32'd1);
    wait_tick("flush");
    chk("flush_underrun", 32'(underrun), 32'd1);
    cyc();
    chk("flush_pcm", 32'(pcm_out), 32'd0);

    // asynchronous reset in the middle of a ramp
    do_reset();
    tune_valid = 1'b1;
    tune_freq  = 32'd100035000;
    cyc();
    tune_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_tick("mid");
      cyc();
    end
    chk("mid_cw_before", cw_freq, 32'd100020000);
    wait_tick("mid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cw", cw_freq, RST_F);
    chk("mid_rst_pcm", 32'(pcm_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tune_ready", 32'(tune_ready), 32'd1);
    chk("mid_rst_tick", 32'(sample_tick), 32'd0);
    repeat (2) @(negedge clk_pcm);
    rst_n   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'd77;
    n = 0;
    cyc();
    n++;
    s_valid = 1'b0;
    while (!sample_tick && n < 40) begin
      cyc();
      n++;
    end
    chk("mid_first_tick_cycles", 32'(n), 32'(SAMPLE_DIV - 1));
    cyc();
    chk("mid_resume_pcm", 32'(pcm_out), 32'd77);
    chk("mid_resume_cw", cw_freq, RST_F);
    chk("mid_resume_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fmgen_ctrl.md
# fmgen_ctrl

Sample-pacing and carrier-tuning controller in front of `fmgen`, in the `clk_pcm` domain. It buffers PCM samples from an audio source in a 4-deep FIFO and releases one sample per sample tick onto `pcm_out`. It owns the carrier frequency word `cw_freq` and retunes it on request through a mute → ramp → settle sequence, so that no audio is transmitted while the carrier moves.

## Interface
Parameters:
- `SAMPLE_DIV`, 1000: `clk_pcm` cycles per sample tick; must be ≥ 2.
- `FIFO_DEPTH`, 4: sample FIFO entries; must be a power of 2.
- `STEP_HZ`, 10000: maximum `cw_freq` change per tick while ramping.
- `SETTLE_TICKS`, 16: muted ticks after the ramp completes; must be ≥ 1.
- `RESET_FREQ`, 107900000: `cw_freq` value after reset, in Hz.

Ports:
- `clk_pcm` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: sample valid.
- `s_data` in 16: signed PCM sample.
- `s_ready` out 1: sample accepted when `s_valid` and `s_ready` are both high.
- `tune_valid` in 1: retune request.
- `tune_freq` in 32: unsigned target carrier frequency in Hz.
- `tune_ready` out 1: request accepted when `tune_valid` and `tune_ready` are both high.
- `cw_freq` out 32: unsigned carrier frequency word to `fmgen`.
- `pcm_out` out 16: signed sample to `fmgen` `pcm_in`.
- `sample_tick` out 1: one-cycle pulse on every sample period.
- `busy` out 1: high whenever the FSM is not in ON_AIR.
- `underrun` out 1: one-cycle pulse when ON_AIR, a tick occurs and the FIFO is empty.

## Operation
- **Tick counter:** free-running, counts 0..`SAMPLE_DIV`-1 and wraps. `sample_tick` is high while the count equals `SAMPLE_DIV`-1. A retune never resets the counter.
- **FIFO:**
  - `s_ready` = FIFO not full AND state is ON_AIR.
  - In ON_AIR, on a tick with the FIFO non-empty: pop the head into `pcm_out`.
  - In ON_AIR, on a tick with the FIFO empty: `pcm_out` holds its value and `underrun` pulses.
  - A push and a pop in the same cycle are both honoured.
  - A push into an empty FIFO on a tick edge is stored; that tick still counts as an underrun.
- **FSM states:**
  - **ON_AIR:** `tune_ready`=1. An accepted tune latches `tune_freq` as the target, flushes the FIFO (same edge) and moves to MUTE.
  - **MUTE:** on the next tick, `pcm_out`←0 and move to RAMP.
  - **RAMP:** on each tick, `pcm_out`←0 and `cw_freq` moves toward the target by min(`STEP_HZ`, |target−`cw_freq`|), in either direction.
    - Move to SETTLE on the tick where `cw_freq` becomes equal to the target.
    - If `cw_freq` already equals the target, move to SETTLE on the first RAMP tick with no change to `cw_freq`.
  - **SETTLE:** on each tick `pcm_out`←0. A tick counter runs; on the `SETTLE_TICKS`-th tick, move to ON_AIR.
- **Arithmetic:** the difference is computed in 33 bits, signed, so `cw_freq` never wraps or overshoots the target. `tune_freq` is unrestricted (0 to 2^32−1).
- `tune_valid` outside ON_AIR is ignored and left pending; it is not dropped, because `tune_ready`=0.

## Timing
- **Reset** (asynchronous assert, synchronous deassert handled upstream):
  - `cw_freq`=`RESET_FREQ`, `pcm_out`=0, FIFO empty, tick count 0, state ON_AIR.
  - `sample_tick`=0, `underrun`=0, `busy`=0, `s_ready`=1, `tune_ready`=1.
- The first `sample_tick` is in the `SAMPLE_DIV`-th cycle after reset release.
- `pcm_out` and `cw_freq` update only on the edge ending a `sample_tick` cycle, and are visible the following cycle.
- **Tune accept edge:** state←MUTE and `busy`=1 from the next cycle. `tune_ready` and `s_ready` drop in that same next cycle.
- **Retune length:** 1 (MUTE) + ceil(|Δ|/`STEP_HZ`) (RAMP, minimum 1) + `SETTLE_TICKS` ticks. ON_AIR is re-entered, and `busy` falls, the cycle after the last SETTLE tick.
- **Async reset mid-retune:** all outputs go to their reset values immediately, the target is lost and the FIFO is emptied.

## Test plan
Bench parameters: `SAMPLE_DIV`=8, `STEP_HZ`=10000, `SETTLE_TICKS`=2, `RESET_FREQ`=100000000.

1. **FIFO drain and underrun:** after reset, push 100, 200, −300 → `pcm_out` = 100, 200, −300 on ticks 1–3; tick 4 → `underrun` pulses once and `pcm_out` stays −300.
2. **FIFO full:** push 5 samples back-to-back before the first tick → `s_ready` low after the 4th accept. After tick 1 pops one entry, the 5th sample is accepted.
3. **Upward retune:** tune 100035000 → `tune_ready`/`s_ready` low, `busy` high.
   - Tick 1: `pcm_out`=0 and `cw_freq` unchanged.
   - Ticks 2–5: `cw_freq` = 100010000, 100020000, 100030000, 100035000.
   - Ticks 6–7: `pcm_out`=0.
   - `busy` falls after tick 7.
4. **Downward and same-frequency retune:** tune 99995000 → ticks 2–3 give `cw_freq` = 99995000 then stays, with SETTLE on ticks 3–4. Then tune to the current frequency → `busy` for exactly 4 ticks with `cw_freq` unchanged.
5. **Flush on retune:** with 3 samples queued, tune 100000000 → FIFO empty; the first tick after ON_AIR gives `underrun` with `pcm_out`=0.
6. **Reset mid-ramp:** assert `rst_n`=0 during RAMP tick 3 → `cw_freq`=100000000, `pcm_out`=0 and `busy`=0 without waiting for a clock edge; normal operation resumes after release.
